// File: rtl/cnn_pkg.sv
// Shared definitions for the 4x4 cellular-network array and its convergence monitor.
package cnn_pkg;

  localparam int CNN_DATA_W  = 9;
  localparam int CNN_N_CELLS = 16;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_RUN   = 2'd1,
    MON_DRAIN = 2'd2,
    MON_DONE  = 2'd3
  } mon_state_e;

  // Saturating 8-bit increment used by the sweep counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'd255) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/cnn_cell_cmp.sv
// Per-cell "unchanged" comparator between the live cell output and its snapshot.
// CNN_CONV_SIGN_ONLY_EN selects a sign-bit-only compare for bipolar templates.
module cnn_cell_cmp #(
  parameter int DATA_W = 9,
  parameter int TOL    = 0
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] prev,
  output logic              unchanged
);

`ifdef CNN_CONV_SIGN_ONLY_EN
  logic unused_low_bits_s;

  assign unused_low_bits_s = ^{cur[DATA_W-2:0], prev[DATA_W-2:0]};
  assign unchanged         = (cur[DATA_W-1] == prev[DATA_W-1]);
`else
  localparam logic [DATA_W:0] TOL_C = TOL[DATA_W:0];

  logic signed [DATA_W:0] diff_s;
  logic        [DATA_W:0] mag_s;

  // One extra bit keeps the difference of two extreme values from wrapping.
  always_comb begin
    diff_s = $signed({cur[DATA_W-1], cur}) - $signed({prev[DATA_W-1], prev});
    if (diff_s[DATA_W]) begin
      mag_s = -diff_s;
    end else begin
      mag_s = diff_s;
    end
    unchanged = (mag_s <= TOL_C);
  end
`endif

endmodule

// File: rtl/cnn_conv_monitor.sv
// Steady-state / iteration-limit monitor for the cellular array; streams the frozen frame out.
// Optional build macro: CNN_CONV_SIGN_ONLY_EN (sign-only cell compare).
module cnn_conv_monitor
  import cnn_pkg::*;
#(
  parameter int DATA_W        = CNN_DATA_W,
  parameter int N_CELLS       = CNN_N_CELLS,
  parameter int MAX_ITER      = 64,
  parameter int STABLE_SWEEPS = 2,
  parameter int TOL           = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      sweep_tick,
  input  logic [N_CELLS*DATA_W-1:0] y_flat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [3:0]                out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      converged,
  output logic                      timeout,
  output logic [7:0]                iter_count
);

  localparam logic [3:0] STABLE_C   = 4'(STABLE_SWEEPS);
  localparam logic [7:0] MAX_C      = 8'(MAX_ITER);
  localparam logic [3:0] LAST_IDX_C = 4'(N_CELLS - 1);

  mon_state_e          state_r, state_nxt_s;
  logic [DATA_W-1:0]   snap_r [N_CELLS];
  logic [N_CELLS-1:0]  cell_same_s;
  logic                frame_stable_s;
  logic [3:0]          stable_r, stable_nxt_s;
  logic                prev_valid_r;
  logic [7:0]          iter_r, iter_nxt_s;
  logic                conv_hit_s, tmo_hit_s;
  logic                handshake_s, clear_run_s, capture_s, enter_drain_s, advance_s;
  logic                busy_nxt_s;
  logic [3:0]          nxt_idx_s;
  logic                out_valid_r, out_last_r, busy_r, converged_r, timeout_r;
  logic [DATA_W-1:0]   out_data_r;
  logic [3:0]          out_idx_r;

  genvar g;
  generate
    for (g = 0; g < N_CELLS; g++) begin : g_cmp
      cnn_cell_cmp #(
        .DATA_W (DATA_W),
        .TOL    (TOL)
      ) u_cmp (
        .cur       (y_flat[g*DATA_W +: DATA_W]),
        .prev      (snap_r[g]),
        .unchanged (cell_same_s[g])
      );
    end
  endgenerate

  // Per-tick stability and iteration decisions; convergence takes priority over timeout.
  always_comb begin
    frame_stable_s = prev_valid_r & (&cell_same_s);
    if (frame_stable_s) begin
      stable_nxt_s = stable_r + 4'd1;
    end else begin
      stable_nxt_s = 4'd0;
    end
    iter_nxt_s = sat_inc8(iter_r);
    conv_hit_s = (stable_nxt_s == STABLE_C);
    tmo_hit_s  = ~conv_hit_s & (iter_nxt_s >= MAX_C);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MON_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MON_IDLE: begin
        if (start) state_nxt_s = MON_RUN;
        else       state_nxt_s = MON_IDLE;
      end
      MON_RUN: begin
        if (start)                                        state_nxt_s = MON_RUN;
        else if (sweep_tick && (conv_hit_s || tmo_hit_s)) state_nxt_s = MON_DRAIN;
        else                                              state_nxt_s = MON_RUN;
      end
      MON_DRAIN: begin
        if (handshake_s && out_last_r) state_nxt_s = MON_DONE;
        else                           state_nxt_s = MON_DRAIN;
      end
      MON_DONE: begin
        if (start) state_nxt_s = MON_RUN;
        else       state_nxt_s = MON_DONE;
      end
      default: state_nxt_s = MON_IDLE;
    endcase
  end

  // Output/control decode feeding the registered outputs and datapath.
  always_comb begin
    handshake_s   = out_valid_r & out_ready;
    nxt_idx_s     = out_idx_r + 4'd1;
    clear_run_s   = 1'b0;
    capture_s     = 1'b0;
    advance_s     = 1'b0;
    case (state_r)
      MON_IDLE:  clear_run_s = 1'b1;
      MON_RUN: begin
        if (start) clear_run_s = 1'b1;
        else       capture_s   = sweep_tick;
      end
      MON_DRAIN: advance_s   = handshake_s;
      MON_DONE:  clear_run_s = start;
      default:   clear_run_s = 1'b1;
    endcase
    enter_drain_s = capture_s & (conv_hit_s | tmo_hit_s);
    if ((state_nxt_s == MON_RUN) || (state_nxt_s == MON_DRAIN)) begin
      busy_nxt_s = 1'b1;
    end else begin
      busy_nxt_s = 1'b0;
    end
  end

  // Run bookkeeping: counters and end-of-run flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_r       <= 8'd0;
      stable_r     <= 4'd0;
      prev_valid_r <= 1'b0;
      converged_r  <= 1'b0;
      timeout_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      if (clear_run_s) begin
        iter_r       <= 8'd0;
        stable_r     <= 4'd0;
        prev_valid_r <= 1'b0;
        converged_r  <= 1'b0;
        timeout_r    <= 1'b0;
      end else if (capture_s) begin
        iter_r       <= iter_nxt_s;
        stable_r     <= stable_nxt_s;
        prev_valid_r <= 1'b1;
        converged_r  <= conv_hit_s;
        timeout_r    <= tmo_hit_s;
      end
    end
  end

  // Frame snapshot, captured on every accepted sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CELLS; k++) snap_r[k] <= '0;
    end else if (capture_s) begin
      for (int k = 0; k < N_CELLS; k++) snap_r[k] <= y_flat[k*DATA_W +: DATA_W];
    end
  end

  // Stream registers; cell 0 is loaded straight from y_flat on the terminating tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= 4'd0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else if (enter_drain_s) begin
      out_valid_r <= 1'b1;
      out_idx_r   <= 4'd0;
      out_data_r  <= y_flat[DATA_W-1:0];
      out_last_r  <= (LAST_IDX_C == 4'd0);
    end else if (advance_s) begin
      if (out_last_r) begin
        out_valid_r <= 1'b0;
        out_idx_r   <= 4'd0;
        out_data_r  <= '0;
        out_last_r  <= 1'b0;
      end else begin
        out_idx_r   <= nxt_idx_s;
        out_data_r  <= snap_r[nxt_idx_s];
        out_last_r  <= (nxt_idx_s == LAST_IDX_C);
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_idx    = out_idx_r;
  assign out_last   = out_last_r;
  assign busy       = busy_r;
  assign converged  = converged_r;
  assign timeout    = timeout_r;
  assign iter_count = iter_r;

endmodule
